// File: rtl/dnn_pkg.sv
// ============================================================================
// Module   : dnn_pkg
// Brief    : Shared CSR word offsets and control FSM state encoding for the
//            dnn_csr_slave / dnn_master pair.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dnn_pkg;

  localparam int unsigned CTRL      = 0;
  localparam int unsigned BIAS      = 1;
  localparam int unsigned WEIGHT    = 2;
  localparam int unsigned ACTIV     = 3;
  localparam int unsigned OUT_ACTIV = 4;
  localparam int unsigned LEN       = 5;
  localparam int unsigned RELU      = 6;
  localparam int unsigned DONECNT   = 7;
  localparam int unsigned STATUS    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } csr_state_t;

endpackage

`default_nettype wire

// File: rtl/dnn_csr_slave.sv
// ============================================================================
// Module   : dnn_csr_slave
// Brief    : Avalon-MM register file that parameterises and launches one
//            dnn_master layer per CTRL write; CTRL reads block until done.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dnn_csr_slave
  import dnn_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  output logic              slave_waitrequest,
  output logic [31:0]       bias_v_addr,
  output logic [31:0]       weight_m_addr,
  output logic [31:0]       activ_addr,
  output logic [31:0]       out_activ_addr,
  output logic [31:0]       activ_len,
  output logic [31:0]       relu,
  output logic              enable,
  input  logic              operating
);

  csr_state_t  r_state;
  logic        r_enable;
  logic [31:0] r_bias;
  logic [31:0] r_weight;
  logic [31:0] r_activ;
  logic [31:0] r_out_activ;
  logic [31:0] r_len;
  logic        r_relu;
  logic [31:0] r_done_count;

  logic        w_busy;
  logic        w_ctrl_sel;
  logic        w_in_map;
  logic        w_wait;
  logic        w_wr_ok;
  logic        w_rd_ok;
  logic [31:0] w_rdata;

  assign w_busy     = (r_state != IDLE);
  assign w_ctrl_sel = (slave_address == ADDR_W'(CTRL));
  assign w_in_map   = (32'(slave_address) < NUM_REGS);

  // Only CTRL accesses stall, and only until the FSM is back in IDLE.
  assign w_wait  = w_ctrl_sel && (slave_read || slave_write) && w_busy;
  assign w_wr_ok = slave_write && !w_wait && w_in_map;
  assign w_rd_ok = slave_read && !slave_write && !w_wait && w_in_map;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_enable     <= 1'b0;
      r_bias       <= '0;
      r_weight     <= '0;
      r_activ      <= '0;
      r_out_activ  <= '0;
      r_len        <= '0;
      r_relu       <= 1'b0;
      r_done_count <= '0;
    end else begin
      if (w_wr_ok) begin
        case (slave_address)
          ADDR_W'(BIAS):      r_bias      <= slave_writedata;
          ADDR_W'(WEIGHT):    r_weight    <= slave_writedata;
          ADDR_W'(ACTIV):     r_activ     <= slave_writedata;
          ADDR_W'(OUT_ACTIV): r_out_activ <= slave_writedata;
          ADDR_W'(LEN):       r_len       <= slave_writedata;
          ADDR_W'(RELU):      r_relu      <= slave_writedata[0];
          default: ;
        endcase
      end

      case (r_state)
        IDLE: begin
          if (w_wr_ok && w_ctrl_sel) begin
            r_state  <= LAUNCH;
            r_enable <= 1'b1;
          end
        end
        LAUNCH: begin
          if (operating) begin
            r_state  <= RUN;
            r_enable <= 1'b0;
          end
        end
        RUN: begin
          if (!operating) r_state <= DONE;
        end
        DONE: begin
          r_done_count <= r_done_count + 32'd1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd_ok) begin
      case (slave_address)
        ADDR_W'(CTRL):      w_rdata = r_done_count;
        ADDR_W'(BIAS):      w_rdata = r_bias;
        ADDR_W'(WEIGHT):    w_rdata = r_weight;
        ADDR_W'(ACTIV):     w_rdata = r_activ;
        ADDR_W'(OUT_ACTIV): w_rdata = r_out_activ;
        ADDR_W'(LEN):       w_rdata = r_len;
        ADDR_W'(RELU):      w_rdata = {31'b0, r_relu};
        ADDR_W'(DONECNT):   w_rdata = r_done_count;
        ADDR_W'(STATUS):    w_rdata = {30'b0, operating, w_busy};
        default:            w_rdata = '0;
      endcase
    end
  end

  assign slave_readdata    = w_rdata;
  assign slave_waitrequest = w_wait;
  assign bias_v_addr       = r_bias;
  assign weight_m_addr     = r_weight;
  assign activ_addr        = r_activ;
  assign out_activ_addr    = r_out_activ;
  assign activ_len         = r_len;
  assign relu              = {31'b0, r_relu};
  assign enable            = r_enable;

endmodule

`default_nettype wire

// File: tb/tb_dnn_csr_slave.sv
// ============================================================================
// Module   : tb_dnn_csr_slave
// Brief    : Directed bench for dnn_csr_slave with a simple dnn_master model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dnn_csr_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] readdata;
  logic        waitreq;
  logic [31:0] bias_v_addr, weight_m_addr, activ_addr, out_activ_addr;
  logic [31:0] activ_len, relu;
  logic        enable;
  logic        operating;

  int n_checks = 0;
  int n_errors = 0;

  dnn_csr_slave #(.ADDR_W(4), .NUM_REGS(9)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .slave_address     (addr),
    .slave_read        (rd),
    .slave_write       (wr),
    .slave_writedata   (wdata),
    .slave_readdata    (readdata),
    .slave_waitrequest (waitreq),
    .bias_v_addr       (bias_v_addr),
    .weight_m_addr     (weight_m_addr),
    .activ_addr        (activ_addr),
    .out_activ_addr    (out_activ_addr),
    .activ_len         (activ_len),
    .relu              (relu),
    .enable            (enable),
    .operating         (operating)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    step(1'b1, 1'b0, a, 32'd0);
    chk(tag, readdata, exp);
    chk({tag, "_wait"}, 32'(waitreq), 32'd0);
  endtask

  // dnn_master model: operating rises 3 cycles after enable is seen, holds 20 cycles.
  initial begin
    int phase;
    int cnt;
    operating = 1'b0;
    phase = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        operating = 1'b0;
        phase = 0;
        cnt = 0;
      end else begin
        case (phase)
          0: if (enable) begin cnt = 1; phase = 1; end
          1: begin
            cnt++;
            if (cnt == 4) begin operating = 1'b1; phase = 2; cnt = 0; end
          end
          default: begin
            cnt++;
            if (cnt == 20) begin operating = 1'b0; phase = 0; end
          end
        endcase
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] wvals [1:6];
    logic [31:0] rvals [1:6];
    wvals = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'd16, 32'hFFFF_FFFF};
    rvals = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'd16, 32'd1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_relu", relu, 32'd0);
    for (int a = 0; a < 16; a++) rd_chk($sformatf("rst_rd%0d", a), 4'(a), 32'd0);

    for (int a = 1; a <= 6; a++) step(1'b0, 1'b1, 4'(a), wvals[a]);
    for (int a = 1; a <= 6; a++) rd_chk($sformatf("rb%0d", a), 4'(a), rvals[a]);
    chk("port_bias", bias_v_addr, 32'h1000);
    chk("port_weight", weight_m_addr, 32'h2000);
    chk("port_activ", activ_addr, 32'h3000);
    chk("port_out", out_activ_addr, 32'h4000);
    chk("port_len", activ_len, 32'd16);
    chk("port_relu", relu, 32'd1);

    // Job A: STATUS polled early, then a blocking CTRL read from RUN.
    step(1'b0, 1'b1, 4'd0, 32'hABCD);
    chk("a_start_wait", 32'(waitreq), 32'd0);
    for (int n = 1; n <= 30; n++) begin
      if (n < 6) begin
        step(1'b1, 1'b0, 4'd8, 32'd0);
        chk($sformatf("a_status%0d", n), readdata, {30'b0, (n >= 4) ? 1'b1 : 1'b0, 1'b1});
      end else if (n <= 26) begin
        step(1'b1, 1'b0, 4'd0, 32'd0);
        chk($sformatf("a_ctrl_wait%0d", n), 32'(waitreq), (n <= 25) ? 32'd1 : 32'd0);
        if (n == 26) chk("a_ctrl_rd", readdata, 32'd1);
      end else begin
        step(1'b0, 1'b0, 4'd0, 32'd0);
      end
      chk($sformatf("a_enable%0d", n), 32'(enable), (n <= 4) ? 32'd1 : 32'd0);
    end
    rd_chk("a_donecnt", 4'd7, 32'd1);
    rd_chk("a_ctrl", 4'd0, 32'd1);
    rd_chk("a_status_idle", 4'd8, 32'd0);

    // Job B, with a back-to-back CTRL write that stalls and then launches job C.
    step(1'b0, 1'b1, 4'd0, 32'd0);
    chk("b_start_wait", 32'(waitreq), 32'd0);
    for (int n = 1; n <= 34; n++) begin
      if (n <= 26) begin
        step(1'b0, 1'b1, 4'd0, 32'd0);
        chk($sformatf("b_wr_wait%0d", n), 32'(waitreq), (n <= 25) ? 32'd1 : 32'd0);
      end else if (n <= 30) begin
        step(1'b0, 1'b0, 4'd0, 32'd0);
        chk($sformatf("c_enable%0d", n), 32'(enable), 32'd1);
      end else begin
        rd_chk($sformatf("b_donecnt%0d", n), 4'd7, 32'd2);
        chk($sformatf("c_enable%0d", n), 32'(enable), 32'd0);
      end
    end

    // Reset while job C is in RUN.
    @(negedge clk);
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_enable", 32'(enable), 32'd0);
    chk("mid_rst_bias", bias_v_addr, 32'd0);
    chk("mid_rst_len", activ_len, 32'd0);
    chk("mid_rst_relu", relu, 32'd0);
    for (int a = 0; a < 16; a++) rd_chk($sformatf("mid_rst_rd%0d", a), 4'(a), 32'd0);

    // Unmapped write, read-only write, and simultaneous read+write.
    step(1'b0, 1'b1, 4'd12, 32'hDEAD_BEEF);
    rd_chk("unmapped12", 4'd12, 32'd0);
    step(1'b0, 1'b1, 4'd7, 32'd99);
    rd_chk("donecnt_ro", 4'd7, 32'd0);
    step(1'b1, 1'b1, 4'd1, 32'h5555);
    chk("rw_rdata", readdata, 32'd0);
    rd_chk("rw_bias", 4'd1, 32'h5555);
    chk("rw_bias_port", bias_v_addr, 32'h5555);
    step(1'b0, 1'b0, 4'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
